stage_if: RTL and testbench

- Instruction-fetch stage, directly upstream of the decode stage.
- Owns the PC and issues single-outstanding requests on the instruction bus.
- Registers each fetched instruction, with its PC+4, into the IF/ID pipeline registers.
- Supports decode-side stall and a branch/jump redirect that flushes the in-flight fetch.

---
 rtl/stage_if_pkg.sv | 15 +
 rtl/stage_if.sv | 157 +++++++++++++++
 tb/tb_stage_if.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package stage_if_pkg;

    // Fetch FSM encoding, kept as plain constants for legacy tool flows.
    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_RESET   = 2'd0;
    localparam fetch_state_t S_FETCH   = 2'd1;
    localparam fetch_state_t S_HOLD    = 2'd2;
    localparam fetch_state_t S_DISCARD = 2'd3;

    // Instruction word used as a pipeline bubble.
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding fetches
// and fills the IF/ID registers. Supports decode stall and redirect flush.
module stage_if #(
    parameter int unsigned                   DATA_IBUS_WIDTH = 32,
    parameter int unsigned                   ADDR_IBUS_WIDTH = 32,
    parameter logic [ADDR_IBUS_WIDTH-1:0]    RESET_PC        = '0,
    parameter logic [DATA_IBUS_WIDTH-1:0]    NOP_INST        = stage_if_pkg::NOP_INST
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_stall,
    input  logic                       i_pc_load,
    input  logic [ADDR_IBUS_WIDTH-1:0] i_pc_target,
    output logic [ADDR_IBUS_WIDTH-1:0] o_ibus_addr,
    output logic                       o_ibus_req,
    input  logic                       i_ibus_ack,
    input  logic [DATA_IBUS_WIDTH-1:0] i_ibus_rdata,
    output logic [DATA_IBUS_WIDTH-1:0] o_inst,
    output logic [ADDR_IBUS_WIDTH-1:0] o_pc_plus4,
    output logic                       o_valid
);
    import stage_if_pkg::*;

    fetch_state_t               r_state;
    logic [ADDR_IBUS_WIDTH-1:0] r_pc;
    logic [ADDR_IBUS_WIDTH-1:0] r_req_addr;
    logic                       r_req;

    logic [DATA_IBUS_WIDTH-1:0] r_buf_inst;
    logic [ADDR_IBUS_WIDTH-1:0] r_buf_pc4;
    logic                       r_buf_valid;

    logic [DATA_IBUS_WIDTH-1:0] r_inst;
    logic [ADDR_IBUS_WIDTH-1:0] r_pc_plus4;
    logic                       r_valid;

    logic [ADDR_IBUS_WIDTH-1:0] w_target;
    logic [ADDR_IBUS_WIDTH-1:0] w_pc_inc;
    logic                       w_ack;
    logic                       w_load_fetch;
    logic                       w_load_buf;

    // Redirect targets are forced word-aligned; PC wraps naturally.
    assign w_target = i_pc_target & ~ADDR_IBUS_WIDTH'(3);
    assign w_pc_inc = r_pc + ADDR_IBUS_WIDTH'(4);

    // Acks without an outstanding request are ignored.
    assign w_ack = i_ibus_ack & r_req;

    // In S_FETCH the request address always equals r_pc.
    assign w_load_fetch = (r_state == S_FETCH) & w_ack & ~i_pc_load & ~i_stall;
    assign w_load_buf   = (r_state == S_HOLD) & r_buf_valid & ~i_pc_load & ~i_stall;

    // Fetch FSM: PC, request address/strobe and the one-entry hold buffer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_RESET;
            r_pc        <= RESET_PC;
            r_req_addr  <= RESET_PC;
            r_req       <= 1'b0;
            r_buf_inst  <= NOP_INST;
            r_buf_pc4   <= '0;
            r_buf_valid <= 1'b0;
        end else begin
            case (r_state)
                S_RESET: begin
                    r_state    <= S_FETCH;
                    r_req      <= 1'b1;
                    r_req_addr <= r_pc;
                end
                S_FETCH: begin
                    if (w_ack) begin
                        if (i_pc_load) begin
                            r_pc       <= w_target;
                            r_req_addr <= w_target;
                        end else if (i_stall) begin
                            r_buf_inst  <= i_ibus_rdata;
                            r_buf_pc4   <= w_pc_inc;
                            r_buf_valid <= 1'b1;
                            r_pc        <= w_pc_inc;
                            r_req       <= 1'b0;
                            r_state     <= S_HOLD;
                        end else begin
                            r_pc       <= w_pc_inc;
                            r_req_addr <= w_pc_inc;
                        end
                    end else if (i_pc_load) begin
                        // Old request stays on the bus until it is acked.
                        r_pc    <= w_target;
                        r_state <= S_DISCARD;
                    end
                end
                S_HOLD: begin
                    if (i_pc_load) begin
                        r_buf_valid <= 1'b0;
                        r_pc        <= w_target;
                        r_req       <= 1'b1;
                        r_req_addr  <= w_target;
                        r_state     <= S_FETCH;
                    end else if (!i_stall) begin
                        r_buf_valid <= 1'b0;
                        r_req       <= 1'b1;
                        r_req_addr  <= r_pc;
                        r_state     <= S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (i_pc_load) begin
                        r_pc <= w_target;
                    end
                    if (w_ack) begin
                        r_req_addr <= i_pc_load ? w_target : r_pc;
                        r_state    <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_RESET;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID registers: flush beats stall, stall beats load, else bubble.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inst     <= NOP_INST;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (i_pc_load) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (i_stall) begin
            r_inst     <= r_inst;
            r_pc_plus4 <= r_pc_plus4;
            r_valid    <= r_valid;
        end else if (w_load_fetch) begin
            r_inst     <= i_ibus_rdata;
            r_pc_plus4 <= w_pc_inc;
            r_valid    <= 1'b1;
        end else if (w_load_buf) begin
            r_inst     <= r_buf_inst;
            r_pc_plus4 <= r_buf_pc4;
            r_valid    <= 1'b1;
        end else begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end
    end

    assign o_ibus_addr = r_req_addr;
    assign o_ibus_req  = r_req;
    assign o_inst      = r_inst;
    assign o_pc_plus4  = r_pc_plus4;
    assign o_valid     = r_valid;

endmodule

// File: tb/tb_stage_if.sv
// Directed testbench for stage_if with a configurable-latency memory model.
module tb_stage_if;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        pc_load;
    logic [31:0] pc_target;
    logic [31:0] ibus_addr;
    logic        ibus_req;
    logic        ibus_ack;
    logic [31:0] ibus_rdata;
    logic [31:0] inst;
    logic [31:0] pc_plus4;
    logic        valid;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Memory model: ack after `lat` wait cycles; force_ack injects stray acks.
    int          lat       = 0;
    bit          mem_en    = 1'b0;
    bit          force_ack = 1'b0;
    int          wcnt      = 0;

    assign ibus_ack   = force_ack | (mem_en & ibus_req & (wcnt == lat));
    assign ibus_rdata = ibus_addr ^ 32'hA5A5_A5A5;

    always @(posedge clk) begin
        if (!ibus_req || ibus_ack) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
    end

    stage_if #(
        .DATA_IBUS_WIDTH(32),
        .ADDR_IBUS_WIDTH(32),
        .RESET_PC       (32'hFFFF_FFFC),
        .NOP_INST       (32'h0000_0000)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_stall     (stall),
        .i_pc_load   (pc_load),
        .i_pc_target (pc_target),
        .o_ibus_addr (ibus_addr),
        .o_ibus_req  (ibus_req),
        .i_ibus_ack  (ibus_ack),
        .i_ibus_rdata(ibus_rdata),
        .o_inst      (inst),
        .o_pc_plus4  (pc_plus4),
        .o_valid     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; pc_load = 1'b0; pc_target = '0;
        mem_en = 1'b0; force_ack = 1'b1;
        repeat (3) step();
        force_ack = 1'b0;
        n_tests++; if (ibus_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: got %b want 0", ibus_req); end
        n_tests++; if (ibus_addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL reset_addr: got %h want fffffffc", ibus_addr); end
        n_tests++; if (inst !== 32'h0) begin
            n_fail++; $display("FAIL reset_inst: got %h want 0", inst); end
        n_tests++; if (pc_plus4 !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc4: got %h want 0", pc_plus4); end
        n_tests++; if (valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    endtask

    // Zero-wait memory starting at the top of the address space (wraps to 0).
    task automatic test_zero_wait();
        logic [31:0] ea;
        logic [31:0] prev;
        rst = 1'b0; mem_en = 1'b1; lat = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            ea   = 32'hFFFF_FFFC + 32'(4 * k);
            prev = ea - 32'd4;
            n_tests++; if (ibus_req !== 1'b1 || ibus_addr !== ea) begin
                n_fail++;
                $display("FAIL zw_addr[%0d]: got req=%b addr=%h want req=1 addr=%h",
                         k, ibus_req, ibus_addr, ea);
            end
            if (k == 0) begin
                n_tests++; if (valid !== 1'b0) begin
                    n_fail++; $display("FAIL zw_valid0: got %b want 0", valid); end
            end else begin
                n_tests++;
                if (valid !== 1'b1 || inst !== (prev ^ 32'hA5A5_A5A5) || pc_plus4 !== ea) begin
                    n_fail++;
                    $display("FAIL zw_ifid[%0d]: got v=%b i=%h p=%h want v=1 i=%h p=%h",
                             k, valid, inst, pc_plus4, prev ^ 32'hA5A5_A5A5, ea);
                end
            end
        end
    endtask

    // Redirect on an ack, then a 3-cycle stall landing on the ack at 0x8.
    task automatic test_stall();
        pc_load = 1'b1; pc_target = 32'h0000_0005;
        step();
        n_tests++;
        if (ibus_addr !== 32'h4 || valid !== 1'b0 || inst !== 32'h0 || pc_plus4 !== 32'hC) begin
            n_fail++;
            $display("FAIL redir_ack: got a=%h v=%b i=%h p=%h want a=4 v=0 i=0 p=c",
                     ibus_addr, valid, inst, pc_plus4);
        end
        pc_load = 1'b0;
        step();
        n_tests++;
        if (valid !== 1'b1 || inst !== 32'hA5A5_A5A1 || pc_plus4 !== 32'h8 || ibus_addr !== 32'h8)
        begin
            n_fail++;
            $display("FAIL pre_stall: got v=%b i=%h p=%h a=%h want v=1 i=a5a5a5a1 p=8 a=8",
                     valid, inst, pc_plus4, ibus_addr);
        end
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            n_tests++;
            if (ibus_req !== 1'b0 || valid !== 1'b1 || inst !== 32'hA5A5_A5A1 ||
                pc_plus4 !== 32'h8) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got r=%b v=%b i=%h p=%h want r=0 v=1 i=a5a5a5a1 p=8",
                         s, ibus_req, valid, inst, pc_plus4);
            end
        end
        stall = 1'b0;
        step();
        n_tests++;
        if (valid !== 1'b1 || inst !== 32'hA5A5_A5AD || pc_plus4 !== 32'hC ||
            ibus_req !== 1'b1 || ibus_addr !== 32'hC) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b i=%h p=%h r=%b a=%h want v=1 i=a5a5a5ad p=c r=1 a=c",
                     valid, inst, pc_plus4, ibus_req, ibus_addr);
        end
        step();
        n_tests++;
        if (valid !== 1'b1 || inst !== 32'hA5A5_A5A9 || pc_plus4 !== 32'h10 ||
            ibus_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL stall_next: got v=%b i=%h p=%h a=%h want v=1 i=a5a5a5a9 p=10 a=10",
                     valid, inst, pc_plus4, ibus_addr);
        end
    endtask

    // Two wait cycles per fetch: request stable, valid pattern 0,0,1.
    task automatic test_wait2();
        logic [31:0] base;
        logic [31:0] ea;
        bit          ev;
        lat = 2;
        for (int j = 0; j < 6; j++) begin
            step();
            base = 32'h10 + 32'(4 * (j / 3));
            ev   = ((j % 3) == 2);
            ea   = ev ? base + 32'd4 : base;
            n_tests++;
            if (ibus_req !== 1'b1 || ibus_addr !== ea || valid !== ev) begin
                n_fail++;
                $display("FAIL wait2[%0d]: got r=%b a=%h v=%b want r=1 a=%h v=%b",
                         j, ibus_req, ibus_addr, valid, ea, ev);
            end
            if (ev) begin
                n_tests++;
                if (inst !== (base ^ 32'hA5A5_A5A5) || pc_plus4 !== base + 32'd4) begin
                    n_fail++;
                    $display("FAIL wait2_data[%0d]: got i=%h p=%h want i=%h p=%h",
                             j, inst, pc_plus4, base ^ 32'hA5A5_A5A5, base + 32'd4);
                end
            end
        end
    endtask

    // Redirect while a slow request is pending; second redirect in discard.
    task automatic test_discard();
        pc_load = 1'b1; pc_target = 32'h80;
        step();
        n_tests++;
        if (ibus_req !== 1'b1 || ibus_addr !== 32'h18 || valid !== 1'b0 ||
            inst !== 32'h0 || pc_plus4 !== 32'h18) begin
            n_fail++;
            $display("FAIL discard_enter: got r=%b a=%h v=%b i=%h p=%h want r=1 a=18 v=0 i=0 p=18",
                     ibus_req, ibus_addr, valid, inst, pc_plus4);
        end
        pc_target = 32'h100;
        step();
        n_tests++;
        if (ibus_req !== 1'b1 || ibus_addr !== 32'h18 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL discard_wait: got r=%b a=%h v=%b want r=1 a=18 v=0",
                     ibus_req, ibus_addr, valid);
        end
        pc_load = 1'b0;
        for (int w = 0; w < 3; w++) begin
            step();
            n_tests++;
            if (ibus_req !== 1'b1 || ibus_addr !== 32'h100 || valid !== 1'b0) begin
                n_fail++;
                $display("FAIL discard_new[%0d]: got r=%b a=%h v=%b want r=1 a=100 v=0",
                         w, ibus_req, ibus_addr, valid);
            end
        end
        step();
        n_tests++;
        if (valid !== 1'b1 || inst !== 32'hA5A5_A4A5 || pc_plus4 !== 32'h104 ||
            ibus_addr !== 32'h104) begin
            n_fail++;
            $display("FAIL discard_fetch: got v=%b i=%h p=%h a=%h want v=1 i=a5a5a4a5 p=104 a=104",
                     valid, inst, pc_plus4, ibus_addr);
        end
    endtask

    // Redirect and stall together: redirect wins, target aligned down.
    task automatic test_load_stall();
        lat = 0;
        pc_load = 1'b1; stall = 1'b1; pc_target = 32'h203;
        step();
        n_tests++;
        if (ibus_req !== 1'b1 || ibus_addr !== 32'h200 || valid !== 1'b0 ||
            inst !== 32'h0 || pc_plus4 !== 32'h104) begin
            n_fail++;
            $display("FAIL load_stall: got r=%b a=%h v=%b i=%h p=%h want r=1 a=200 v=0 i=0 p=104",
                     ibus_req, ibus_addr, valid, inst, pc_plus4);
        end
        pc_load = 1'b0; stall = 1'b0;
        step();
        n_tests++;
        if (valid !== 1'b1 || inst !== 32'hA5A5_A7A5 || pc_plus4 !== 32'h204 ||
            ibus_addr !== 32'h204) begin
            n_fail++;
            $display("FAIL load_stall_next: got v=%b i=%h p=%h a=%h want v=1 i=a5a5a7a5 p=204 a=204",
                     valid, inst, pc_plus4, ibus_addr);
        end
    endtask

    // Reset during a pending request; stray acks in reset are ignored.
    task automatic test_reset_mid();
        lat = 2;
        rst = 1'b1;
        step();
        n_tests++;
        if (ibus_req !== 1'b0 || ibus_addr !== 32'hFFFF_FFFC || valid !== 1'b0 ||
            inst !== 32'h0 || pc_plus4 !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got r=%b a=%h v=%b i=%h p=%h want r=0 a=fffffffc v=0 i=0 p=0",
                     ibus_req, ibus_addr, valid, inst, pc_plus4);
        end
        force_ack = 1'b1;
        step();
        rst = 1'b0;
        step();
        force_ack = 1'b0;
        n_tests++;
        if (ibus_req !== 1'b1 || ibus_addr !== 32'hFFFF_FFFC || valid !== 1'b0 ||
            pc_plus4 !== 32'h0) begin
            n_fail++;
            $display("FAIL late_ack: got r=%b a=%h v=%b p=%h want r=1 a=fffffffc v=0 p=0",
                     ibus_req, ibus_addr, valid, pc_plus4);
        end
        repeat (2) step();
        n_tests++;
        if (ibus_addr !== 32'hFFFF_FFFC || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_wait: got a=%h v=%b want a=fffffffc v=0",
                     ibus_addr, valid);
        end
        step();
        n_tests++;
        if (valid !== 1'b1 || inst !== 32'h5A5A_5A59 || pc_plus4 !== 32'h0 ||
            ibus_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL post_reset_fetch: got v=%b i=%h p=%h a=%h want v=1 i=5a5a5a59 p=0 a=0",
                     valid, inst, pc_plus4, ibus_addr);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; pc_load = 1'b0; pc_target = '0;
        test_reset();
        test_zero_wait();
        test_stall();
        test_wait2();
        test_discard();
        test_load_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
